// File: rtl/cv32e40s_pkg.sv
// Shared definitions for the Zknh functional unit: operation enum, encodings, pipeline stage record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional SHA-512 RV32 support in the users of this package is guarded by CV32E40S_ZKNH_SHA512_EN.
package cv32e40s_pkg;

  typedef enum logic [3:0] {
    ZKNH_SHA256SUM0,
    ZKNH_SHA256SUM1,
    ZKNH_SHA256SIG0,
    ZKNH_SHA256SIG1,
    ZKNH_SHA512SUM0R,
    ZKNH_SHA512SUM1R,
    ZKNH_SHA512SIG0L,
    ZKNH_SHA512SIG0H,
    ZKNH_SHA512SIG1L,
    ZKNH_SHA512SIG1H
  } zknh_op_e;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] F3_SHA256 = 3'b001;
  localparam logic [2:0] F3_SHA512 = 3'b000;

  // SHA-256 ops live in OP-IMM: funct7=0001000 followed by a 5-bit selector.
  localparam logic [11:0] F12_SHA256SUM0 = 12'b0001000_00000;
  localparam logic [11:0] F12_SHA256SUM1 = 12'b0001000_00001;
  localparam logic [11:0] F12_SHA256SIG0 = 12'b0001000_00010;
  localparam logic [11:0] F12_SHA256SIG1 = 12'b0001000_00011;

  localparam logic [6:0] F7_SHA512SUM0R = 7'b0101000;
  localparam logic [6:0] F7_SHA512SUM1R = 7'b0101001;
  localparam logic [6:0] F7_SHA512SIG0L = 7'b0101010;
  localparam logic [6:0] F7_SHA512SIG1L = 7'b0101011;
  localparam logic [6:0] F7_SHA512SIG0H = 7'b0101110;
  localparam logic [6:0] F7_SHA512SIG1H = 7'b0101111;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
  } zknh_stage_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/cv32e40s_zknh_datapath.sv
// Zknh arithmetic: maps an operation and rs1/rs2 to the 32-bit result.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing unit registers the result.
// Ports: op (operation), rs1/rs2 (operands), result (output).
// Macro CV32E40S_ZKNH_SHA512_EN builds the RV32 SHA-512 half-word formulas.
module cv32e40s_zknh_datapath
  import cv32e40s_pkg::*;
(
  input  zknh_op_e    op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] result
);

  always_comb begin
    result = 32'h0;
    case (op)
      ZKNH_SHA256SUM0: result = ror32(rs1, 2) ^ ror32(rs1, 13) ^ ror32(rs1, 22);
      ZKNH_SHA256SUM1: result = ror32(rs1, 6) ^ ror32(rs1, 11) ^ ror32(rs1, 25);
      ZKNH_SHA256SIG0: result = ror32(rs1, 7) ^ ror32(rs1, 18) ^ (rs1 >> 3);
      ZKNH_SHA256SIG1: result = ror32(rs1, 17) ^ ror32(rs1, 19) ^ (rs1 >> 10);
`ifdef CV32E40S_ZKNH_SHA512_EN
      // rs1/rs2 hold the two halves of a 64-bit word; each formula is the
      // 32-bit slice of the 64-bit rotate/shift expression.
      ZKNH_SHA512SUM0R: result = (rs1 << 25) ^ (rs1 << 30) ^ (rs1 >> 28) ^
                                 (rs2 >> 7) ^ (rs2 >> 2) ^ (rs2 << 4);
      ZKNH_SHA512SUM1R: result = (rs1 << 23) ^ (rs1 >> 14) ^ (rs1 >> 18) ^
                                 (rs2 >> 9) ^ (rs2 << 18) ^ (rs2 << 14);
      ZKNH_SHA512SIG0L: result = (rs1 >> 1) ^ (rs1 >> 7) ^ (rs1 >> 8) ^
                                 (rs2 << 31) ^ (rs2 << 25) ^ (rs2 << 24);
      ZKNH_SHA512SIG0H: result = (rs1 >> 1) ^ (rs1 >> 7) ^ (rs1 >> 8) ^
                                 (rs2 << 31) ^ (rs2 << 24);
      ZKNH_SHA512SIG1L: result = (rs1 << 3) ^ (rs1 >> 6) ^ (rs1 >> 19) ^
                                 (rs2 >> 29) ^ (rs2 << 26) ^ (rs2 << 13);
      ZKNH_SHA512SIG1H: result = (rs1 << 3) ^ (rs1 >> 6) ^ (rs1 >> 19) ^
                                 (rs2 >> 29) ^ (rs2 << 13);
`endif
      default: result = 32'h0;
    endcase
  end

`ifndef CV32E40S_ZKNH_SHA512_EN
  // SHA-256 only needs rs1.
  logic unused_rs2;
  assign unused_rs2 = ^rs2;
`endif

endmodule

// File: rtl/cv32e40s_zknh_unit.sv
// Zknh EX-stage unit: decodes SHA-256 (and optionally RV32 SHA-512) ops, computes, pipelines the result.
// Latency: PIPE_STAGES cycles from accept edge to valid_o when unstalled; one op per cycle throughput.
// Backpressure: ready_i low holds the last stage; upper stages fill, ready_o drops only when all are full.
// Ports: valid_i/ready_o/instr_i/rs1_i/rs2_i/rd_i (offer), illegal_o (comb decode fault), kill_i (flush),
//        valid_o/ready_i/result_o/rd_o (result), busy_o (any stage occupied).
// Macro CV32E40S_ZKNH_SHA512_EN enables the OP-opcode SHA-512 RV32 decode and datapath.
module cv32e40s_zknh_unit
  import cv32e40s_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  output logic        illegal_o,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        busy_o
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_depth
    $error("cv32e40s_zknh_unit: PIPE_STAGES must be 1..3");
  end

  localparam int LAST = PIPE_STAGES - 1;

  // ---------------- decode ----------------
  zknh_op_e    op;
  logic        legal;
  logic [31:0] dp_result;
  logic        accept;

  always_comb begin
    op    = ZKNH_SHA256SUM0;
    legal = 1'b0;
    if (instr_i[6:0] == OPCODE_OP_IMM && instr_i[14:12] == F3_SHA256) begin
      legal = 1'b1;
      case (instr_i[31:20])
        F12_SHA256SUM0: op = ZKNH_SHA256SUM0;
        F12_SHA256SUM1: op = ZKNH_SHA256SUM1;
        F12_SHA256SIG0: op = ZKNH_SHA256SIG0;
        F12_SHA256SIG1: op = ZKNH_SHA256SIG1;
        default:        legal = 1'b0;
      endcase
    end
`ifdef CV32E40S_ZKNH_SHA512_EN
    else if (instr_i[6:0] == OPCODE_OP && instr_i[14:12] == F3_SHA512) begin
      legal = 1'b1;
      case (instr_i[31:25])
        F7_SHA512SUM0R: op = ZKNH_SHA512SUM0R;
        F7_SHA512SUM1R: op = ZKNH_SHA512SUM1R;
        F7_SHA512SIG0L: op = ZKNH_SHA512SIG0L;
        F7_SHA512SIG1L: op = ZKNH_SHA512SIG1L;
        F7_SHA512SIG0H: op = ZKNH_SHA512SIG0H;
        F7_SHA512SIG1H: op = ZKNH_SHA512SIG1H;
        default:        legal = 1'b0;
      endcase
    end
`endif
  end

  // Register fields and rs2 slot of the encoding reach the unit through the ports.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[19:15], instr_i[11:7]};

  assign illegal_o = valid_i & ~legal;

  cv32e40s_zknh_datapath u_datapath (
    .op     (op),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .result (dp_result)
  );

  // ---------------- result pipeline ----------------
  zknh_stage_t            stage_q  [PIPE_STAGES];
  zknh_stage_t            stage_in [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] adv;

  // A stage may take new data if the consumer is ready or any slot at or
  // below it is empty; written without a self-referencing chain.
  always_comb begin
    for (int i = 0; i < PIPE_STAGES; i++) begin
      logic any_empty;
      any_empty = 1'b0;
      for (int j = i; j < PIPE_STAGES; j++) begin
        any_empty = any_empty | ~stage_q[j].valid;
      end
      adv[i] = ready_i | any_empty;
    end
  end

  assign ready_o = adv[0];
  assign accept  = valid_i & ready_o & ~illegal_o & ~kill_i;

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage_in
    if (g == 0) begin : g_head
      assign stage_in[g] = '{valid: accept, result: dp_result, rd: rd_i};
    end else begin : g_body
      assign stage_in[g] = stage_q[g-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) stage_q[i] <= '0;
    end else if (kill_i) begin
      for (int i = 0; i < PIPE_STAGES; i++) stage_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (adv[i]) begin
          stage_q[i].valid <= stage_in[i].valid;
          // Payload only moves with a valid entry so a stalled output stays put.
          if (stage_in[i].valid) begin
            stage_q[i].result <= stage_in[i].result;
            stage_q[i].rd     <= stage_in[i].rd;
          end
        end
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < PIPE_STAGES; i++) busy_o = busy_o | stage_q[i].valid;
  end

  assign valid_o  = stage_q[LAST].valid;
  assign result_o = stage_q[LAST].result;
  assign rd_o     = stage_q[LAST].rd;

endmodule

// File: tb/tb_cv32e40s_zknh_unit.sv
module tb_cv32e40s_zknh_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        kill_i;
  logic        ready_i;

  logic [2:0]  ready_o;
  logic [2:0]  illegal_o;
  logic [2:0]  valid_o;
  logic [2:0]  busy_o;
  logic [31:0] result_o [3];
  logic [4:0]  rd_o     [3];

  // Instance g has PIPE_STAGES = g+1; all share the same inputs.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    cv32e40s_zknh_unit #(.PIPE_STAGES(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_i),
      .ready_o   (ready_o[g]),
      .instr_i   (instr_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .rd_i      (rd_i),
      .illegal_o (illegal_o[g]),
      .kill_i    (kill_i),
      .valid_o   (valid_o[g]),
      .ready_i   (ready_i),
      .result_o  (result_o[g]),
      .rd_o      (rd_o[g]),
      .busy_o    (busy_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_imm(input logic [4:0] sel);
    return {7'b0001000, sel, 5'd1, 3'b001, 5'd2, 7'b0010011};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] res;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    #4 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [4:0] rd);
    valid_i = 1'b1;
    instr_i = instr;
    rs1_i   = rs1;
    rs2_i   = 32'hDEADBEEF;
    rd_i    = rd;
  endtask

  logic [31:0] got_res [$];
  logic [4:0]  got_rd  [$];
  logic [31:0] bp_res  [3];
  logic [4:0]  bp_rd   [3];
  int          seen;

  initial begin
    vecs[0]  = '{"sum0_1",      mk_imm(5'd0), 32'h00000001, 32'hDEADBEEF, 5'd3,  1'b0, 32'h40080400};
    vecs[1]  = '{"sum1_1",      mk_imm(5'd1), 32'h00000001, 32'hDEADBEEF, 5'd5,  1'b0, 32'h04200080};
    vecs[2]  = '{"sig0_1",      mk_imm(5'd2), 32'h00000001, 32'hDEADBEEF, 5'd7,  1'b0, 32'h02004000};
    vecs[3]  = '{"sig1_1",      mk_imm(5'd3), 32'h00000001, 32'hDEADBEEF, 5'd9,  1'b0, 32'h0000A000};
    vecs[4]  = '{"sig0_msb",    mk_imm(5'd2), 32'h80000000, 32'hDEADBEEF, 5'd1,  1'b0, 32'h11002000};
    vecs[5]  = '{"sig1_msb",    mk_imm(5'd3), 32'h80000000, 32'hDEADBEEF, 5'd31, 1'b0, 32'h00205000};
    vecs[6]  = '{"sum0_ones",   mk_imm(5'd0), 32'hFFFFFFFF, 32'hDEADBEEF, 5'd2,  1'b0, 32'hFFFFFFFF};
    vecs[7]  = '{"sum1_b8",     mk_imm(5'd1), 32'h00000100, 32'hDEADBEEF, 5'd4,  1'b0, 32'h20008004};
    vecs[8]  = '{"sig0_b3",     mk_imm(5'd2), 32'h00000008, 32'hDEADBEEF, 5'd6,  1'b0, 32'h10020001};
    vecs[9]  = '{"sig1_b10",    mk_imm(5'd3), 32'h00000400, 32'hDEADBEEF, 5'd8,  1'b0, 32'h02800001};
    vecs[10] = '{"ill_sel5",    mk_imm(5'd5), 32'h00000001, 32'hDEADBEEF, 5'd11, 1'b1, 32'h0};
`ifdef CV32E40S_ZKNH_SHA512_EN
    vecs[11] = '{"sum0r",       {7'b0101000, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011},
                 32'h00000001, 32'h00000000, 5'd12, 1'b0, 32'h42000000};
`else
    vecs[11] = '{"ill_sum0r",   {7'b0101000, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011},
                 32'h00000001, 32'h00000000, 5'd12, 1'b1, 32'h0};
`endif
    vecs[12] = '{"ill_funct3",  {7'b0001000, 5'd0, 5'd1, 3'b000, 5'd2, 7'b0010011},
                 32'h00000001, 32'hDEADBEEF, 5'd13, 1'b1, 32'h0};
    vecs[13] = '{"ill_opcode",  {7'b0001000, 5'd0, 5'd1, 3'b001, 5'd2, 7'b0110011},
                 32'h00000001, 32'hDEADBEEF, 5'd14, 1'b1, 32'h0};

    bp_res = '{32'h40080400, 32'h04200080, 32'h02004000};
    bp_rd  = '{5'd10, 5'd11, 5'd12};

    // ---- reset state, observed before any clock edge ----
    rst_n   = 1'b0;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    ready_i = 1'b1;
    instr_i = 32'h0;
    rs1_i   = 32'h0;
    rs2_i   = 32'h0;
    rd_i    = 5'd0;
    #3;
    check("rst_valid",  32'(valid_o[0]), 32'd0);
    check("rst_busy",   32'(busy_o[0]),  32'd0);
    check("rst_ready",  32'(ready_o[0]), 32'd1);
    check("rst_result", result_o[0],     32'h0);
    check("rst_rd",     32'(rd_o[0]),    32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    // ---- table: decode, function, latency for depth 1 and depth 3 ----
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      valid_i = 1'b1;
      instr_i = vecs[i].instr;
      rs1_i   = vecs[i].rs1;
      rs2_i   = vecs[i].rs2;
      rd_i    = vecs[i].rd;
      #1;
      check({vecs[i].name, "_illegal"}, 32'(illegal_o[0]), 32'(vecs[i].ill));
      check({vecs[i].name, "_ready"},   32'(ready_o[0]),   32'd1);
      @(posedge clk);
      #1 valid_i = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_p1_valid"}, 32'(valid_o[0]), 32'(!vecs[i].ill));
      if (vecs[i].ill) begin
        check({vecs[i].name, "_p3_busy"}, 32'(busy_o[2]), 32'd0);
      end else begin
        check({vecs[i].name, "_p1_result"}, result_o[0],    vecs[i].res);
        check({vecs[i].name, "_p1_rd"},     32'(rd_o[0]),   32'(vecs[i].rd));
      end
      check({vecs[i].name, "_p3_c1"}, 32'(valid_o[2]), 32'd0);
      @(negedge clk);
      check({vecs[i].name, "_p3_c2"}, 32'(valid_o[2]), 32'd0);
      @(negedge clk);
      check({vecs[i].name, "_p3_c3"}, 32'(valid_o[2]), 32'(!vecs[i].ill));
      if (!vecs[i].ill) check({vecs[i].name, "_p3_result"}, result_o[2], vecs[i].res);
    end

    // ---- backpressure on depth 2 ----
    do_reset();
    ready_i = 1'b0;
    @(posedge clk);
    #1 offer(mk_imm(5'd0), 32'h1, 5'd10);
    @(negedge clk);
    check("bp_ready_a", 32'(ready_o[1]), 32'd1);
    @(posedge clk);
    #1 offer(mk_imm(5'd1), 32'h1, 5'd11);
    @(negedge clk);
    check("bp_ready_b", 32'(ready_o[1]), 32'd1);
    @(posedge clk);
    #1 offer(mk_imm(5'd2), 32'h1, 5'd12);
    @(negedge clk);
    check("bp_ready_full", 32'(ready_o[1]), 32'd0);
    check("bp_valid_hold", 32'(valid_o[1]), 32'd1);
    check("bp_result_hold", result_o[1], 32'h40080400);
    @(negedge clk);
    check("bp_result_stable", result_o[1], 32'h40080400);
    check("bp_rd_stable", 32'(rd_o[1]), 32'd10);
    @(posedge clk);
    #1 ready_i = 1'b1;
    #1 check("bp_passthrough_ready", 32'(ready_o[1]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_o[1]) begin
        got_res.push_back(result_o[1]);
        got_rd.push_back(rd_o[1]);
      end
      @(posedge clk);
      #1 valid_i = 1'b0;
    end
    check("bp_count", 32'(got_res.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_res.size()) begin
        check($sformatf("bp_res%0d", k), got_res[k], bp_res[k]);
        check($sformatf("bp_rd%0d", k),  32'(got_rd[k]), 32'(bp_rd[k]));
      end
    end
    check("bp_busy_end", 32'(busy_o[1]), 32'd0);

    // ---- kill with full pipe and pending offer ----
    do_reset();
    ready_i = 1'b0;
    @(posedge clk);
    #1 offer(mk_imm(5'd0), 32'h1, 5'd10);
    @(posedge clk);
    #1 offer(mk_imm(5'd1), 32'h1, 5'd11);
    @(posedge clk);
    #1 offer(mk_imm(5'd3), 32'h1, 5'd20);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("kill_valid", 32'(valid_o[1]), 32'd0);
    check("kill_busy",  32'(busy_o[1]),  32'd0);
    check("kill_busy3", 32'(busy_o[2]),  32'd0);
    check("kill_ready", 32'(ready_o[1]), 32'd1);
    ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (|valid_o) seen++;
    end
    check("kill_no_emerge", 32'(seen), 32'd0);

    // kill with room available: the offer is dropped
    @(posedge clk);
    #1 offer(mk_imm(5'd0), 32'h1, 5'd21);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("kill_drop_busy", 32'(busy_o[2]), 32'd0);

    // ---- asynchronous reset mid-stream ----
    do_reset();
    ready_i = 1'b0;
    @(posedge clk);
    #1 offer(mk_imm(5'd0), 32'h1, 5'd10);
    @(posedge clk);
    #1 offer(mk_imm(5'd1), 32'h1, 5'd11);
    @(posedge clk);
    #1 valid_i = 1'b0;
    check("arst_pre_valid", 32'(valid_o[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(valid_o[1]), 32'd0);
    check("arst_busy",   32'(busy_o[1]),  32'd0);
    check("arst_busy3",  32'(busy_o[2]),  32'd0);
    check("arst_ready",  32'(ready_o[1]), 32'd1);
    check("arst_result", result_o[1],     32'h0);
    check("arst_rd",     32'(rd_o[1]),    32'd0);
    #1 rst_n = 1'b1;
    ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (|valid_o) seen++;
    end
    check("arst_no_emerge", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40s_zknh_unit.md
# cv32e40s_zknh_unit

Multi-cycle Zknh functional unit for the cv32e40s EX stage: decodes and executes the SHA-256 instructions and, optionally, the RV32 SHA-512 instructions. It sits beside the ALU and owns its own valid/ready handshake and a parametrised result pipeline, so it can absorb downstream stalls without holding ID. Non-Zknh encodings are flagged illegal and never enter the pipeline.

## Interface

**Parameters**
- `PIPE_STAGES`, default 1: result pipeline depth. Legal values are 1..3; any other value is an elaboration error.

**Ports**
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  an instruction is offered.
- `ready_o`  out  1  the unit accepts the offer this cycle.
- `instr_i`  in  32  raw instruction word.
- `rs1_i`, `rs2_i`  in  32  operands.
- `rd_i`  in  5  destination register.
- `illegal_o`  out  1  combinational; high when `valid_i` is high and `instr_i` is not a supported Zknh encoding.
- `kill_i`  in  1  flush all in-flight entries.
- `valid_o`  out  1  a result is available.
- `ready_i`  in  1  downstream consumes the result.
- `result_o`  out  32  result data.
- `rd_o`  out  5  destination register of the result.
- `busy_o`  out  1  at least one stage holds a valid entry.

## Operation

**Decode**
- OP-IMM with funct7=0001000 and funct3=001 selects on bits [24:20]:
  - 00000 = sum0
  - 00001 = sum1
  - 00010 = sig0
  - 00011 = sig1
  - any other value is illegal.
- OP with funct3=000 selects on funct7 (SHA-512 only, see Configuration):
  - 0101000 = sum0r
  - 0101001 = sum1r
  - 0101010 = sig0l
  - 0101011 = sig1l
  - 0101110 = sig0h
  - 0101111 = sig1h
- All other encodings assert `illegal_o`.

**Function**
- sum0 = ror2 ^ ror13 ^ ror22
- sum1 = ror6 ^ ror11 ^ ror25
- sig0 = ror7 ^ ror18 ^ srl3
- sig1 = ror17 ^ ror19 ^ srl10
- The SHA-512 RV32 variants follow the ratified Zknh v1.0.1 shift/xor formulas on rs1/rs2.
- All shifts are 32-bit logical; bits shifted out are discarded.
- The result is computed combinationally from the inputs and captured in stage 0.

**Pipeline**
- Stages 0..PIPE_STAGES-1, each holding {valid, result, rd}.
- The last stage drives `valid_o`, `result_o` and `rd_o`.
- A stage advances when it is empty or when its successor advances (last stage: when `ready_i` is high).
- `ready_o` = stage 0 can accept.
- Accept occurs when `valid_i & ready_o & !illegal_o & !kill_i`.
- An illegal instruction is never accepted. `ready_o` still reflects capacity; ID raises the exception.

**Kill**
- `kill_i` clears every valid bit at the next edge.
- An offer made in the same cycle is dropped.
- Kill has priority over accept and over consume.

**Reset**
- Asynchronous. Clears all valid bits, result and rd to 0.
- After reset: `valid_o`=0, `busy_o`=0, `ready_o`=1, `result_o`=0, `rd_o`=0.
- Reset asserted mid-operation discards all entries.

## Timing

- Latency: the result is on `valid_o` exactly PIPE_STAGES cycles after the accept edge when no stall occurs.
- Throughput: one instruction per cycle while `ready_i` stays high.
- Backpressure:
  - With `ready_i` low, `result_o` and `rd_o` hold stable until consumed.
  - Upper stages fill; `ready_o` drops only when all stages are full and the last stage is not consumed.
- Simultaneous accept and consume with a full pipe: `ready_o` is 1 (pass-through), so there is no bubble.
- `illegal_o` and `ready_o` carry no combinational path from `valid_o`.
- `ready_o` depends combinationally on `ready_i` through the advance chain.

## Configuration

- Macro `CV32E40S_ZKNH_SHA512_EN`.
- **Defined:** the OP-opcode SHA-512 RV32 decode and its datapath are built.
- **Undefined:** those encodings assert `illegal_o` and no SHA-512 logic is synthesised. SHA-256 behaviour is identical in both builds.

## Structure

**Shared package `cv32e40s_pkg`**
- `zknh_op_e` enum covering the 10 operations.
- funct7/funct12 encoding constants.
- `zknh_stage_t` struct {valid, result, rd}.

**Sub-module `cv32e40s_zknh_datapath`**
- Purely combinational: `zknh_op_e` + rs1/rs2 -> result.
- The top module holds the decode, the pipeline registers and the handshake.

## Test plan

- **SHA-256 sums.** PIPE_STAGES=1, sha256sum0 with rs1=0x00000001 -> `valid_o` one cycle later, `result_o`=0x40080400. sha256sum1 with rs1=0x00000001 -> `result_o`=0x04200080.
- **SHA-256 sig0 latency.** sha256sig0 with rs1=0x00000001 and rd=7 -> `result_o`=0x02004000, `rd_o`=7. With PIPE_STAGES=3 the result appears exactly 3 cycles after accept.
- **Backpressure.** PIPE_STAGES=2, `ready_i`=0 while 3 instructions are issued back to back -> `ready_o` falls after the 2nd accept. Raising `ready_i` drains the results in order with no loss or duplication.
- **Illegal encodings.** OP-IMM with funct12 0001000_00101 -> `illegal_o`=1, no accept, `busy_o` stays 0. With the macro undefined, sha512sum0r -> `illegal_o`=1.
- **Kill.** Kill while the pipe is full and an offer is pending -> next cycle `valid_o`=0 and `busy_o`=0, and the offered instruction never emerges.
- **Reset mid-operation.** Assert `rst_n`=0 mid-stream -> outputs take their reset values immediately, before the next clock edge.
